// File: rtl/instr_perf_counters_pkg.sv
// ----------------------------------------------------------------------------
// instr_perf_pkg
// Shared definitions for the retire-side performance counter bank:
//   - RV32 major opcode constants used for classification
//   - counter index enum (class counters 0..9, CYCLES 10, RETIRED 11)
//   - bank size and read-map address constants
// No ports (package).
// ----------------------------------------------------------------------------
package instr_perf_pkg;

  localparam int NUM_CNT   = 12;
  localparam int NUM_CLASS = 10;

  // RV32 major opcodes (instr[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Counter index map; also the read address of each counter
  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I_ALU   = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_OTHER   = 4'd9,
    CLS_CYCLES  = 4'd10,
    CLS_RETIRED = 4'd11
  } cnt_idx_e;

  // Read map: addresses above ADDR_LAST are unpopulated and read as 0
  localparam logic [3:0] ADDR_FIRST = 4'd0;
  localparam logic [3:0] ADDR_LAST  = 4'd11;

endpackage

// File: rtl/instr_perf_counters_if.sv
// ----------------------------------------------------------------------------
// instr_perf_counters_if
// Bundles the retire-side input and the host command/read port of the
// performance counter bank.
//   retire : instr_valid, instr[INSTR_W], ctrlf
//   host   : clr, snap, rd_en, rd_addr[4] -> rd_data[CNT_W], rd_valid,
//            ovf[NUM_CNT]
// Modports: master (retire stage / host side), slave (counter bank).
// ----------------------------------------------------------------------------
interface instr_perf_counters_if
  import instr_perf_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 17
) ();

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               ctrlf;
  logic               clr;
  logic               snap;
  logic               rd_en;
  logic [3:0]         rd_addr;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_valid;
  logic [NUM_CNT-1:0] ovf;

  modport master (
    output instr_valid, instr, ctrlf, clr, snap, rd_en, rd_addr,
    input  rd_data, rd_valid, ovf
  );

  modport slave (
    input  instr_valid, instr, ctrlf, clr, snap, rd_en, rd_addr,
    output rd_data, rd_valid, ovf
  );

endinterface

// File: rtl/instr_perf_counters_decode.sv
// ----------------------------------------------------------------------------
// instr_class_decode
// Combinational opcode classifier. Produces a one-hot class vector with
// exactly one bit set when the count condition holds, all zero otherwise.
//   i_opcode   in  7          instr[6:0] of the retiring instruction
//   i_count_en in  1          instr_valid && !ctrlf
//   o_class_oh out NUM_CLASS  one-hot class (bit index = counter index)
// ----------------------------------------------------------------------------
module instr_class_decode
  import instr_perf_pkg::*;
(
  input  logic [6:0]           i_opcode,
  input  logic                 i_count_en,
  output logic [NUM_CLASS-1:0] o_class_oh
);

  // Opcode to one-hot class; anything unrecognised lands in OTHER
  always_comb begin
    o_class_oh = {NUM_CLASS{1'b0}};
    if (i_count_en) begin
      case (i_opcode)
        OPC_R:      o_class_oh[CLS_R]      = 1'b1;
        OPC_I_ALU:  o_class_oh[CLS_I_ALU]  = 1'b1;
        OPC_STORE:  o_class_oh[CLS_STORE]  = 1'b1;
        OPC_LOAD:   o_class_oh[CLS_LOAD]   = 1'b1;
        OPC_BRANCH: o_class_oh[CLS_BRANCH] = 1'b1;
        OPC_LUI:    o_class_oh[CLS_LUI]    = 1'b1;
        OPC_AUIPC:  o_class_oh[CLS_AUIPC]  = 1'b1;
        OPC_JAL:    o_class_oh[CLS_JAL]    = 1'b1;
        OPC_JALR:   o_class_oh[CLS_JALR]   = 1'b1;
        default:    o_class_oh[CLS_OTHER]  = 1'b1;
      endcase
    end else begin
      o_class_oh = {NUM_CLASS{1'b0}};
    end
  end

endmodule

// File: rtl/instr_perf_counters.sv
// ----------------------------------------------------------------------------
// instr_perf_counters
// Retire-side performance counter bank: nine opcode classes plus OTHER,
// CYCLES and RETIRED. Live counters are copied to a snapshot bank on snap;
// the host reads only the snapshot through a 1-cycle registered read port.
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of instr_perf_counters_if (retire + host port)
// Optional feature macro: PERF_SATURATE_EN -- counters saturate at their
// maximum instead of wrapping (ovf is set in both modes).
// ----------------------------------------------------------------------------
module instr_perf_counters
  import instr_perf_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_perf_counters_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]     r_cnt  [NUM_CNT];
  logic [CNT_W-1:0]     r_snap [NUM_CNT];
  logic [NUM_CNT-1:0]   r_ovf;
  logic [CNT_W-1:0]     r_rd_data;
  logic                 r_rd_valid;

  logic [INSTR_W-1:0]   w_instr;
  logic                 w_unused_instr;
  logic                 w_cnt_en;
  logic [NUM_CLASS-1:0] w_class_oh;
  logic [NUM_CNT-1:0]   w_inc;
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_CNT];
  logic [NUM_CNT-1:0]   w_ovf_nxt;
  logic [CNT_W-1:0]     w_rd_mux;

  assign w_instr        = bus.instr;
  assign w_unused_instr = ^w_instr[INSTR_W-1:7];
  assign w_cnt_en       = bus.instr_valid & ~bus.ctrlf;

  instr_class_decode u_decode (
    .i_opcode   (w_instr[6:0]),
    .i_count_en (w_cnt_en),
    .o_class_oh (w_class_oh)
  );

  // Per-index increment request: RETIRED, CYCLES (always), then class bits
  assign w_inc = {w_cnt_en, 1'b1, w_class_oh};

  // Next live value per counter, handling wrap/saturate and sticky overflow
  always_comb begin
    w_ovf_nxt = r_ovf;
    for (int i = 0; i < NUM_CNT; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_nxt[i] = 1'b1;
`ifdef PERF_SATURATE_EN
          w_cnt_nxt[i] = CNT_MAX;
`else
          w_cnt_nxt[i] = CNT_ZERO;
`endif
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Live counters and ovf; clr wins over any increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= CNT_ZERO;
      r_ovf <= {NUM_CNT{1'b0}};
    end else if (bus.clr) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= CNT_ZERO;
      r_ovf <= {NUM_CNT{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_ovf <= w_ovf_nxt;
    end
  end

  // Snapshot bank takes the registered (pre-increment, pre-clear) live values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) r_snap[i] <= CNT_ZERO;
    end else if (bus.snap) begin
      for (int i = 0; i < NUM_CNT; i++) r_snap[i] <= r_cnt[i];
    end
  end

  // Read mux over the snapshot; unpopulated addresses return zero
  always_comb begin
    w_rd_mux = CNT_ZERO;
    if (bus.rd_addr <= ADDR_LAST) begin
      w_rd_mux = r_snap[bus.rd_addr];
    end else begin
      w_rd_mux = CNT_ZERO;
    end
  end

  // Registered read port; data holds between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= CNT_ZERO;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_instr_perf_counters.sv
// ----------------------------------------------------------------------------
// tb_instr_perf_counters
// Self-checking bench for instr_perf_counters. Counter width is reduced so
// the wrap/saturate boundary is reachable in a short run. Honours
// PERF_SATURATE_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_instr_perf_counters;
  import instr_perf_pkg::*;

  localparam int          TB_CNT_W = 10;
  localparam int unsigned TB_MOD   = 32'd1 << TB_CNT_W;
  localparam int unsigned TB_MAX   = TB_MOD - 32'd1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_perf_counters_if #(.INSTR_W(32), .CNT_W(TB_CNT_W)) bus ();

  instr_perf_counters #(.INSTR_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_cnt  [12];
  int unsigned m_snap [12];
  logic [11:0] m_ovf;
  int unsigned m_rd_data;
  logic        m_rd_valid;

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0100011: return 2;
      7'b0000011: return 3;
      7'b1100011: return 4;
      7'b0110111: return 5;
      7'b0010111: return 6;
      7'b1101111: return 7;
      7'b1100111: return 8;
      default:    return 9;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    m_ovf      = 12'd0;
    m_rd_data  = 0;
    m_rd_valid = 1'b0;
  endtask

  task automatic bump(input int i);
`ifdef PERF_SATURATE_EN
    if (m_cnt[i] + 1 > TB_MAX) m_ovf[i] = 1'b1;
    else m_cnt[i] = m_cnt[i] + 1;
`else
    if (m_cnt[i] + 1 >= TB_MOD) m_ovf[i] = 1'b1;
    m_cnt[i] = (m_cnt[i] + 1) % TB_MOD;
`endif
  endtask

  // One clock: drive at negedge, advance the model at posedge, return at negedge
  task automatic step(input logic v, input logic [31:0] ins, input logic cf,
                      input logic c, input logic s, input logic re,
                      input logic [3:0] a);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.ctrlf       = cf;
    bus.clr         = c;
    bus.snap        = s;
    bus.rd_en       = re;
    bus.rd_addr     = a;
    @(posedge clk);
    m_rd_valid = re;
    if (re) m_rd_data = (a < 4'd12) ? m_snap[a] : 0;
    if (s) for (int i = 0; i < 12; i++) m_snap[i] = m_cnt[i];
    if (c) begin
      for (int i = 0; i < 12; i++) m_cnt[i] = 0;
      m_ovf = 12'd0;
    end else begin
      if (v && !cf) begin
        bump(cls_of(ins[6:0]));
        bump(11);
      end
      bump(10);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = op;
    return w;
  endfunction

  task automatic test_reset();
    int want [16];
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.ctrlf = 1'b0;
    bus.clr = 1'b0; bus.snap = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.ovf !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b data=%0d ovf=%h, want 0/0/000",
               bus.rd_valid, bus.rd_data, bus.ovf);
    end
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) want[a] = 0;
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) ||
          bus.rd_data !== TB_CNT_W'(want[a])) begin
        errors++;
        $display("FAIL reset_read idx%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                 a, bus.rd_valid, bus.rd_data, want[a]);
      end
    end
    idle();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== TB_CNT_W'(m_rd_data)) begin
      errors++;
      $display("FAIL read_hold: got valid=%b data=%0d, want valid=0 data=%0d",
               bus.rd_valid, bus.rd_data, m_rd_data);
    end
  endtask

  task automatic test_class_mix();
    int want [16];
    logic [6:0] ops [7];
    ops = '{7'b0110011, 7'b0000011, 7'b0110011, 7'b1100111,
            7'b0000011, 7'b0001111, 7'b0110011};
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 7; k++) step(1'b1, mk(ops[k]), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) want[a] = 0;
    want[0] = 3; want[3] = 2; want[8] = 1; want[9] = 1; want[11] = 7;
    want[10] = -1;
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) ||
          (want[a] >= 0 && bus.rd_data !== TB_CNT_W'(want[a]))) begin
        errors++;
        $display("FAIL class_mix idx%0d: got valid=%b data=%0d, want valid=1 data=%0d (const %0d)",
                 a, bus.rd_valid, bus.rd_data, m_rd_data, want[a]);
      end
    end
  endtask

  task automatic test_ctrlf();
    int want [16];
    logic fl [5];
    fl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) step(1'b1, mk(OPC_BRANCH), fl[k], 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, mk(OPC_R), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) want[a] = 0;
    want[4] = 3; want[11] = 3; want[10] = -1;
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) ||
          (want[a] >= 0 && bus.rd_data !== TB_CNT_W'(want[a]))) begin
        errors++;
        $display("FAIL ctrlf_squash idx%0d: got valid=%b data=%0d, want valid=1 data=%0d (const %0d)",
                 a, bus.rd_valid, bus.rd_data, m_rd_data, want[a]);
      end
    end
  endtask

  task automatic test_snap_clear();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (10) idle();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) || bus.rd_data < 10) begin
      errors++;
      $display("FAIL snap_clr_old_cycles: got valid=%b data=%0d, want valid=1 data=%0d (>=10)",
               bus.rd_valid, bus.rd_data, m_rd_data);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < 12; a++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) ||
          bus.rd_data !== TB_CNT_W'((a == 10) ? 1 : 0)) begin
        errors++;
        $display("FAIL snap_clr_new idx%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                 a, bus.rd_valid, bus.rd_data, m_rd_data);
      end
    end
    checks++;
    if (bus.ovf !== m_ovf || bus.ovf !== 12'd0) begin
      errors++;
      $display("FAIL snap_clr_ovf: got %h, want %h", bus.ovf, m_ovf);
    end
  endtask

  task automatic test_overflow();
    int unsigned exp1;
`ifdef PERF_SATURATE_EN
    exp1 = TB_MAX;
`else
    exp1 = 0;
`endif
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < int'(TB_MOD); k++) step(1'b1, mk(OPC_I_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) ||
        bus.rd_data !== TB_CNT_W'(exp1)) begin
      errors++;
      $display("FAIL overflow_idx1: got valid=%b data=%0d, want valid=1 data=%0d",
               bus.rd_valid, bus.rd_data, exp1);
    end
    checks++;
    if (bus.ovf[1] !== 1'b1 || bus.ovf !== m_ovf) begin
      errors++;
      $display("FAIL overflow_ovf: got %h, want %h (bit1 set)", bus.ovf, m_ovf);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) step(1'b1, mk(OPC_STORE), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    bus.rd_en = 1'b1;
    bus.rd_addr = 4'd11;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.ovf !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b data=%0d ovf=%h, want 0/0/000",
               bus.rd_valid, bus.rd_data, bus.ovf);
    end
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int a = 0; a < 12; a++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== TB_CNT_W'(m_rd_data) || bus.rd_data !== '0) begin
        errors++;
        $display("FAIL reset_mid_read idx%0d: got valid=%b data=%0d, want valid=1 data=0",
                 a, bus.rd_valid, bus.rd_data);
      end
    end
    checks++;
    if (bus.ovf !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_ovf: got %h, want 000", bus.ovf);
    end
  endtask

  task automatic test_random();
    logic [6:0] tbl [11];
    logic [6:0] op;
    logic v, cf, c, s, re;
    logic [3:0] a;
    tbl = '{OPC_R, OPC_I_ALU, OPC_STORE, OPC_LOAD, OPC_BRANCH, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, 7'b0001111, 7'b1110011};
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 400; k++) begin
      op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 10)];
      v  = ($urandom_range(0, 3) != 0);
      cf = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 2) != 0);
      a  = 4'($urandom);
      step(v, mk(op), cf, c, s, re, a);
      checks++;
      if (bus.rd_valid !== m_rd_valid || (re && bus.rd_data !== TB_CNT_W'(m_rd_data)) ||
          bus.ovf !== m_ovf) begin
        errors++;
        $display("FAIL random cyc%0d addr%0d: got valid=%b data=%0d ovf=%h, want valid=%b data=%0d ovf=%h",
                 k, a, bus.rd_valid, bus.rd_data, bus.ovf, m_rd_valid, m_rd_data, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_class_mix();
    test_ctrlf();
    test_snap_clear();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
